// File: rtl/scan_host_reader_if.sv
// Host-side bus to the readout module: scan control plus hit-memory read port.
interface scan_host_reader_if;
  logic        START;
  logic        SEL;
  logic [7:0]  HADDR;
  logic        BUSY;
  logic [23:0] HDATA;
  logic [8:0]  HNHIT;

  modport master (output START, SEL, HADDR, input BUSY, HDATA, HNHIT);
  modport slave  (input START, SEL, HADDR, output BUSY, HDATA, HNHIT);
endinterface

// File: rtl/scan_host_reader.sv
// Host initiator: starts a readout scan, then streams a header (hit count) and each hit word.
// Best case one word per RD_LAT+1 cycles; stream words hold stable until out_ready.
module scan_host_reader #(
  parameter int RD_LAT  = 1,
  parameter int BUSY_TO = 16,
  parameter int SCAN_TO = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trig,
  scan_host_reader_if.master host,
  output logic [23:0]        out_data,
  output logic               out_valid,
  output logic               out_sof,
  input  logic               out_ready,
  output logic               active,
  output logic               err_to,
  output logic [7:0]         drop_cnt
);
  localparam int CNT_MAX = (SCAN_TO > BUSY_TO) ? SCAN_TO : BUSY_TO;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] LAT_LAST   = CW'(RD_LAT - 1);
  localparam logic [CW-1:0] LAT_SETTLE = CW'(RD_LAT);
  localparam logic [CW-1:0] BUSY_LAST  = CW'(BUSY_TO - 1);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_TO - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_STRT, S_WAIT_HI, S_WAIT_LO, S_RD_N, S_HDR, S_RD, S_PUSH, S_END
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [8:0]    nhit, idx, idx_inc;
  logic [23:0]   word;
  logic [7:0]    haddr;
  logic          lat_done, busy_seen, busy_to, scan_to, last_word;

  // cnt is the dwell time in the current state; it restarts on every transition
  assign lat_done  = (cnt == LAT_LAST);
  assign busy_seen = (cnt >= LAT_SETTLE) && host.BUSY;
  assign busy_to   = (cnt == BUSY_LAST);
  assign scan_to   = (cnt == SCAN_LAST);
  assign idx_inc   = idx + 9'd1;
  assign last_word = (idx_inc == nhit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (trig) state_nxt = S_STRT;
      S_STRT:    state_nxt = S_WAIT_HI;
      S_WAIT_HI: if (busy_seen || busy_to) state_nxt = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!host.BUSY)   state_nxt = S_RD_N;
        else if (scan_to) state_nxt = S_HDR;
      end
      S_RD_N:    if (lat_done) state_nxt = S_HDR;
      S_HDR:     if (out_ready) state_nxt = (nhit == 9'd0) ? S_END : S_RD;
      S_RD:      if (lat_done) state_nxt = S_PUSH;
      S_PUSH:    if (out_ready) state_nxt = last_word ? S_END : S_RD;
      S_END:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    host.START = 1'b0;
    host.SEL   = 1'b0;
    active     = 1'b0;
    out_valid  = 1'b0;
    out_sof    = 1'b0;
    out_data   = 24'h0;
    case (state)
      S_IDLE: ;
      S_END:  active = 1'b1;
      default: begin
        active   = 1'b1;
        host.SEL = 1'b1;
        if (state == S_STRT) host.START = 1'b1;
        if (state == S_HDR) begin
          out_valid = 1'b1;
          out_sof   = 1'b1;
          out_data  = {15'h0, nhit};
        end
        if (state == S_PUSH) begin
          out_valid = 1'b1;
          out_data  = word;
        end
      end
    endcase
  end

  assign host.HADDR = haddr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nhit     <= '0;
      idx      <= '0;
      word     <= '0;
      haddr    <= '0;
      err_to   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (trig && state == S_IDLE) err_to <= 1'b0;
      if (trig && state != S_IDLE && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      case (state)
        S_WAIT_LO: if (host.BUSY && scan_to) begin
          err_to <= 1'b1;
          nhit   <= '0;
        end
        // counts above 256 are illegal from the readout side; clamp to a full memory
        S_RD_N: if (lat_done) nhit <= (host.HNHIT > 9'd256) ? 9'd256 : host.HNHIT;
        S_HDR: if (out_ready && nhit != 9'd0) begin
          idx   <= '0;
          haddr <= '0;
        end
        S_RD: if (lat_done) word <= host.HDATA;
        S_PUSH: if (out_ready) begin
          idx <= idx_inc;
          if (!last_word) haddr <= idx[7:0] + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_scan_host_reader.sv
// Runs two readers (RD_LAT 1 and 3) against a readout-module model; streams are compared
// against an expected event built from the hit memory contents.
module tb_scan_host_reader;
  localparam int LAT_B = 3;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic trig      = 1'b0;
  logic out_ready = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  scan_host_reader_if bus_a ();
  scan_host_reader_if bus_b ();
  logic [23:0] data_a, data_b;
  logic        valid_a, valid_b, sof_a, sof_b, act_a, act_b, err_a, err_b;
  logic [7:0]  drop_a, drop_b;

  scan_host_reader dut_a (
    .clk(clk), .rst_n(rst_n), .trig(trig), .host(bus_a),
    .out_data(data_a), .out_valid(valid_a), .out_sof(sof_a), .out_ready(out_ready),
    .active(act_a), .err_to(err_a), .drop_cnt(drop_a));

  scan_host_reader #(.RD_LAT(LAT_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .trig(trig), .host(bus_b),
    .out_data(data_b), .out_valid(valid_b), .out_sof(sof_b), .out_ready(out_ready),
    .active(act_b), .err_to(err_b), .drop_cnt(drop_b));

  // readout module: BUSY for busy_len cycles after START, hit memory with 1 or 3 cycle latency
  logic [15:0] adc_mem [256];
  logic [8:0]  hnhit = 9'd0;
  int          busy_mode = 0;
  int          busy_len = 20;
  int          bcnt_a = 0;
  int          bcnt_b = 0;
  logic [7:0]  pb1 = 8'h0;
  logic [7:0]  pb2 = 8'h0;

  function automatic int busy_load();
    return (busy_mode == 1) ? 0 : (busy_mode == 2) ? 1000000 : busy_len;
  endfunction

  always @(posedge clk) begin
    if (bus_a.START) bcnt_a <= busy_load(); else if (bcnt_a > 0) bcnt_a <= bcnt_a - 1;
    if (bus_b.START) bcnt_b <= busy_load(); else if (bcnt_b > 0) bcnt_b <= bcnt_b - 1;
    pb1 <= bus_b.HADDR;
    pb2 <= pb1;
  end

  assign bus_a.BUSY  = (bcnt_a != 0);
  assign bus_a.HDATA = {bus_a.HADDR, adc_mem[bus_a.HADDR]};
  assign bus_a.HNHIT = hnhit;
  assign bus_b.BUSY  = (bcnt_b != 0);
  assign bus_b.HDATA = {pb2, adc_mem[pb2]};
  assign bus_b.HNHIT = hnhit;

  // stream monitors: record accepted words, flag any change while a word waits
  logic [24:0] rx_a[$];
  logic [24:0] rx_b[$];
  int          starts_a = 0, starts_b = 0;
  bit          stab_bad_a = 0, stab_bad_b = 0, held_a = 0, held_b = 0;
  logic [24:0] held_w_a = '0, held_w_b = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      held_a = 0;
      held_b = 0;
    end else begin
      if (held_a && !(valid_a && {sof_a, data_a} == held_w_a)) stab_bad_a = 1;
      if (held_b && !(valid_b && {sof_b, data_b} == held_w_b)) stab_bad_b = 1;
      held_a = valid_a && !out_ready;
      held_b = valid_b && !out_ready;
      held_w_a = {sof_a, data_a};
      held_w_b = {sof_b, data_b};
      if (valid_a && out_ready) rx_a.push_back({sof_a, data_a});
      if (valid_b && out_ready) rx_b.push_back({sof_b, data_b});
      if (bus_a.START) starts_a++;
      if (bus_b.START) starts_b++;
    end
  end

  // 0: always ready, 1: toggle with random 10-cycle stalls, 2: accept only reader A's header
  int rdy_mode = 0;
  int hold = 0;
  always @(negedge clk) begin
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin
        if (hold > 0) begin
          out_ready = 1'b0;
          hold--;
        end else if ($urandom_range(0, 11) == 0) begin
          out_ready = 1'b0;
          hold = 9;
        end else begin
          out_ready = !out_ready;
        end
      end
      default: out_ready = valid_a && sof_a;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic run_event(input string tag, input bit exp_err, input int extra);
    logic [24:0] exp_q[$];
    int nh, n, sel_fall_n, act_fall_n, sel_fall_rx;
    bit sel_prev;
    rx_a.delete();
    rx_b.delete();
    starts_a = 0; starts_b = 0; stab_bad_a = 0; stab_bad_b = 0;
    @(negedge clk) trig = 1'b1;
    @(negedge clk) trig = 1'b0;
    for (int k = 0; k < extra; k++) begin
      @(negedge clk) trig = 1'b1;
      @(negedge clk) trig = 1'b0;
    end
    n = 0; sel_fall_n = -1; act_fall_n = -1; sel_fall_rx = -1;
    sel_prev = bus_a.SEL;
    while ((act_a || act_b) && n < 8000) begin
      @(negedge clk);
      n++;
      if (sel_prev && !bus_a.SEL && sel_fall_n < 0) begin
        sel_fall_n  = n;
        sel_fall_rx = rx_a.size();
      end
      if (!act_a && act_fall_n < 0) act_fall_n = n;
      sel_prev = bus_a.SEL;
    end
    chk({tag, "_done"}, 32'(n < 8000), 1);
    nh = exp_err ? 0 : ((hnhit > 9'd256) ? 256 : int'(hnhit));
    exp_q.push_back({1'b1, 15'h0, 9'(nh)});
    for (int i = 0; i < nh; i++) exp_q.push_back({1'b0, 8'(i), adc_mem[i]});
    chk({tag, "_len_a"}, rx_a.size(), exp_q.size());
    chk({tag, "_len_b"}, rx_b.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_word%0d_a", tag, i), (i < rx_a.size()) ? rx_a[i] : 'x, exp_q[i]);
      chk($sformatf("%s_word%0d_b", tag, i), (i < rx_b.size()) ? rx_b[i] : 'x, exp_q[i]);
    end
    chk({tag, "_starts_a"}, starts_a, 1);
    chk({tag, "_starts_b"}, starts_b, 1);
    chk({tag, "_stable_a"}, stab_bad_a, 0);
    chk({tag, "_stable_b"}, stab_bad_b, 0);
    chk({tag, "_err_a"}, err_a, exp_err);
    chk({tag, "_err_b"}, err_b, exp_err);
    chk({tag, "_sel_after_last"}, sel_fall_rx, exp_q.size());
    chk({tag, "_active_lag"}, act_fall_n - sel_fall_n, 1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) adc_mem[i] = 16'($urandom);
    // trig held through reset must not start anything
    trig = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_start", bus_a.START, 0);
    chk("rst_sel", bus_a.SEL, 0);
    chk("rst_haddr", bus_a.HADDR, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_sof", sof_a, 0);
    chk("rst_active", act_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_drop", drop_a, 0);
    chk("rst_active_b", act_b, 0);
    trig = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", act_a, 0);

    adc_mem[0] = 16'd100; adc_mem[1] = 16'd2000; adc_mem[2] = 16'd5555; adc_mem[3] = 16'd500;
    hnhit = 9'd4;
    busy_len = 20;
    run_event("nominal", 0, 3);
    chk("overlap_drop_a", drop_a, 3);
    chk("overlap_drop_b", drop_b, 3);

    hnhit = 9'd0;
    run_event("zero", 0, 0);
    chk("zero_haddr_a", bus_a.HADDR, 3);
    chk("zero_haddr_b", bus_b.HADDR, 3);

    for (int i = 0; i < 4; i++) adc_mem[i] = 16'($urandom);
    busy_len = $urandom_range(5, 30);
    hnhit = 9'd4;
    rdy_mode = 1;
    run_event("backpressure", 0, 0);
    rdy_mode = 0;

    for (int i = 0; i < 256; i++) adc_mem[i] = 16'($urandom);
    hnhit = 9'd256;
    run_event("full", 0, 0);
    chk("full_haddr_a", bus_a.HADDR, 8'hFF);
    chk("full_haddr_b", bus_b.HADDR, 8'hFF);
    hnhit = 9'd300;
    run_event("clamp", 0, 0);

    busy_mode = 2;
    run_event("scan_to", 1, 300);
    chk("drop_sat_a", drop_a, 8'hFF);
    chk("drop_sat_b", drop_b, 8'hFF);
    busy_mode = 1;
    hnhit = 9'd2;
    run_event("busy_to", 0, 0);
    busy_mode = 0;

    // reset while reader A stalls in its first hit word
    hnhit = 9'd4;
    rdy_mode = 2;
    @(negedge clk) trig = 1'b1;
    @(negedge clk) trig = 1'b0;
    n = 0;
    while (!(valid_a && !sof_a) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_reached", 32'(n < 200), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_start", bus_a.START, 0);
    chk("midrst_sel", bus_a.SEL, 0);
    chk("midrst_valid", valid_a, 0);
    chk("midrst_active", act_a, 0);
    chk("midrst_sel_b", bus_b.SEL, 0);
    chk("midrst_active_b", act_b, 0);
    chk("midrst_drop", drop_a, 0);
    rst_n = 1'b1;
    rdy_mode = 0;
    run_event("after_rst", 0, 0);
    chk("after_rst_drop", drop_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
